// File: rtl/cpu_fetch_pkg.sv
// Shared fetch definitions: fetch FSM states and long-form opcode test.
// Also used by the disassembler/trace to size instructions.
package cpu_fetch_pkg;

   typedef enum logic [1:0] {
      F_RUN   = 2'd0,
      F_WAIT  = 2'd1,
      F_DRAIN = 2'd2
   } fetch_state_t;

   function automatic logic is_long(input logic [15:0] op);
      logic hit;
      hit = 1'b0;
      case (op[13:8])
         6'h01, 6'h03, 6'h08, 6'h09,
         6'h0C, 6'h0D, 6'h1A, 6'h1B,
         6'h1D, 6'h1F, 6'h20, 6'h22,
         6'h24, 6'h36, 6'h37, 6'h38,
         6'h39: hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return (op[15:14] == 2'b00) && hit;
   endfunction

endpackage

// File: rtl/cpu_ififo.sv
// Halfword FIFO: single push, 1- or 3-entry pop, peek of three head
// entries, synchronous clear.
module cpu_ififo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [15:0]              push_data,
   input  logic [1:0]               pop_cnt,
   output logic [15:0]              head0,
   output logic [15:0]              head1,
   output logic [15:0]              head2,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   // Push and pop may both hit the same cycle, even when full.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop_cnt);
         count  <= count + CW'(push) - CW'(pop_cnt);
      end
   end

   assign head0 = mem[rd_ptr];
   assign head1 = mem[rd_ptr + AW'(1)];
   assign head2 = mem[rd_ptr + AW'(2)];

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch: halfword reads into a FIFO, opcode/operand
// assembly, one instruction per cycle to decode.
module cpu_fetch
   import cpu_fetch_pkg::*;
#(
   parameter logic [31:0] BOOT_ADDR  = 32'h0000_1000,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] imem_address_o,
   output logic        imem_read_o,
   input  logic [15:0] imem_data_i,
   input  logic        imem_ack_i,
   input  logic        flush_i,
   input  logic [31:0] flush_target_i,
   input  logic        stall_i,
   output logic [15:0] opcode_o,
   output logic [31:0] operand_o,
   output logic [31:0] pc_o,
   output logic        valid_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  state;
   fetch_state_t  state_n;
   logic [31:0]   fetch_addr;
   logic [31:0]   req_addr;
   logic [31:0]   issue_pc;
   logic [31:0]   target;
   logic [CW-1:0] count;
   logic [CW-1:0] avail;
   logic [CW-1:0] need;
   logic [15:0]   h0, h1, h2;
   logic [15:0]   e0, e1, e2;
   logic          fetch;
   logic          push;
   logic          long_op;
   logic          load;
   logic [1:0]    pop_cnt;

   assign target = {flush_target_i[31:1], 1'b0};

   cpu_ififo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (flush_i),
      .push      (push),
      .push_data (imem_data_i),
      .pop_cnt   (pop_cnt),
      .head0     (h0),
      .head1     (h1),
      .head2     (h2),
      .count     (count)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state <= F_RUN;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      fetch   = 1'b0;
      push    = 1'b0;
      unique case (state)
         F_RUN: begin
            fetch = !flush_i && (count < CW'(FIFO_DEPTH));
            if (fetch)
               state_n = F_WAIT;
         end
         F_WAIT: begin
            if (imem_ack_i) begin
               push    = !flush_i;
               state_n = F_RUN;
            end else if (flush_i) begin
               state_n = F_DRAIN;
            end
         end
         F_DRAIN: begin
            if (imem_ack_i)
               state_n = F_RUN;
         end
         default: state_n = F_RUN;
      endcase
   end

   assign imem_read_o    = (fetch && !rst_i) || (state != F_RUN);
   assign imem_address_o = (state == F_RUN) ? fetch_addr : req_addr;

   // Incoming ack data is visible to issue in the same cycle.
   always_comb begin
      avail   = count + CW'(push);
      e0      = (count != '0)       ? h0 : imem_data_i;
      e1      = (count >  CW'(1))   ? h1 : imem_data_i;
      e2      = (count >  CW'(2))   ? h2 : imem_data_i;
      long_op = is_long(e0);
      need    = long_op ? CW'(3) : CW'(1);
      load    = !flush_i && (!valid_o || !stall_i) && (avail >= need);
      pop_cnt = 2'd0;
      if (load)
         pop_cnt = long_op ? 2'd3 : 2'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_addr <= BOOT_ADDR;
         req_addr   <= BOOT_ADDR;
         issue_pc   <= BOOT_ADDR;
         valid_o    <= 1'b0;
         opcode_o   <= '0;
         operand_o  <= '0;
         pc_o       <= BOOT_ADDR;
      end else begin
         if (fetch)
            req_addr <= fetch_addr;
         if (flush_i) begin
            fetch_addr <= target;
            issue_pc   <= target;
            valid_o    <= 1'b0;
         end else begin
            if (push)
               fetch_addr <= fetch_addr + 32'd2;
            if (load) begin
               opcode_o  <= e0;
               operand_o <= long_op ? {e1, e2} : 32'h0;
               pc_o      <= issue_pc;
               issue_pc  <= issue_pc + (long_op ? 32'd6 : 32'd2);
               valid_o   <= 1'b1;
            end else if (!stall_i) begin
               valid_o <= 1'b0;
            end
         end
      end
   end

endmodule
